ptw_axi_read_master: RTL and testbench

- Memory-side responder for the TLB page-table-walk request port. It accepts a single-cycle PTE read request (address pulse) from an Itlb/Dtlb-style walker.
- It performs one 64-bit AXI4 single-beat read and returns the PTE word as a one-cycle valid pulse.
- It sits between the TLB walker and the L2/AXI interconnect. It is the counterpart of the walker's ADDR_TO_AXIM / DATA_FROM_AXIM handshake.

---
 rtl/ptw_axi_read_master.sv | 162 ++++++++++++++++
 tb/tb_ptw_axi_read_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : ptw_axi_read_master
// Brief    : Memory-side responder for the TLB page-table-walk port. Turns a
//            one-cycle PTE read request into a single-beat 64-bit AXI4 read
//            and returns the PTE word as a one-cycle valid pulse.
// Options  : PTW_ALIGN_CHECK_EN - when defined, a request whose address is
//            not 8-byte aligned is answered immediately with ACCESS_FAULT=1
//            and no AXI transaction is issued.
// Revision : 1.0 - initial release
// ============================================================================
module ptw_axi_read_master #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         ADDR_WIDTH     = 64,
    parameter int         AXI_ADDR_WIDTH = 56,
    parameter logic [3:0] AXI_ID         = 4'd0
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    // walker side
    input  logic                      ADDR_FROM_TLB_VALID,
    input  logic [ADDR_WIDTH-1:0]     ADDR_FROM_TLB,
    output logic                      DATA_TO_TLB_VALID,
    output logic [DATA_WIDTH-1:0]     DATA_TO_TLB,
    output logic                      ACCESS_FAULT,
    output logic                      BUSY,
    output logic                      REQ_DROPPED,
    // AXI4 read address channel
    output logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    output logic [3:0]                M_AXI_ARID,
    output logic [7:0]                M_AXI_ARLEN,
    output logic [2:0]                M_AXI_ARSIZE,
    output logic [1:0]                M_AXI_ARBURST,
    output logic [2:0]                M_AXI_ARPROT,
    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RLAST,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_arvalid;
    logic                      r_rready;
    logic                      r_data_valid;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_fault;
    logic                      r_busy;
    logic                      r_req_dropped;
    logic                      w_misaligned;

    // Single-beat, 8-byte, INCR, privileged-data read; only the address varies.
    assign M_AXI_ARID    = AXI_ID;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b011;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARPROT  = 3'b001;

    assign M_AXI_ARADDR      = r_araddr;
    assign M_AXI_ARVALID     = r_arvalid;
    assign M_AXI_RREADY      = r_rready;
    assign DATA_TO_TLB_VALID = r_data_valid;
    assign DATA_TO_TLB       = r_data;
    assign ACCESS_FAULT      = r_fault;
    assign BUSY              = r_busy;
    assign REQ_DROPPED       = r_req_dropped;

`ifdef PTW_ALIGN_CHECK_EN
    // A PTE is 8 bytes; any non-zero low address bits make the walk invalid.
    assign w_misaligned = |ADDR_FROM_TLB[2:0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Upper request address bits and RRESP[0] carry no meaning for this block.
    generate
        if (ADDR_WIDTH > AXI_ADDR_WIDTH) begin : g_addr_hi_unused
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = &{1'b0, ADDR_FROM_TLB[ADDR_WIDTH-1:AXI_ADDR_WIDTH]};
        end
    endgenerate
    logic w_unused_rresp;
    assign w_unused_rresp = &{1'b0, M_AXI_RRESP[0]};

    // Request/response FSM; every output is registered so reset drops them at once.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state       <= IDLE;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_data_valid  <= 1'b0;
            r_data        <= '0;
            r_fault       <= 1'b0;
            r_busy        <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            // The walker never holds a request, so a pulse seen while busy is lost.
            if (ADDR_FROM_TLB_VALID && (r_state != IDLE)) begin
                r_req_dropped <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (ADDR_FROM_TLB_VALID) begin
                        r_busy <= 1'b1;
                        if (w_misaligned) begin
                            r_data       <= '0;
                            r_fault      <= 1'b1;
                            r_data_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_araddr  <= ADDR_FROM_TLB[AXI_ADDR_WIDTH-1:0];
                            r_arvalid <= 1'b1;
                            r_state   <= AR;
                        end
                    end
                end
                AR: begin
                    if (r_arvalid && M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= R;
                    end
                end
                R: begin
                    if (r_rready && M_AXI_RVALID) begin
                        r_data       <= M_AXI_RDATA;
                        // SLVERR/DECERR, or a beat that is not the last of a
                        // single-beat burst, means the PTE cannot be trusted.
                        r_fault      <= M_AXI_RRESP[1] | ~M_AXI_RLAST;
                        r_rready     <= 1'b0;
                        r_data_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_data_valid <= 1'b0;
                    r_fault      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptw_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptw_axi_read_master
// Brief    : Directed scoreboard bench for ptw_axi_read_master. Stimulus
//            pushes expected {fault, data} responses; a monitor pops and
//            compares on every DATA_TO_TLB_VALID pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptw_axi_read_master;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        ADDR_FROM_TLB_VALID = 1'b0;
    logic [63:0] ADDR_FROM_TLB = '0;
    logic        DATA_TO_TLB_VALID;
    logic [63:0] DATA_TO_TLB;
    logic        ACCESS_FAULT;
    logic        BUSY;
    logic        REQ_DROPPED;
    logic [55:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [3:0]  M_AXI_ARID;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [2:0]  M_AXI_ARPROT;
    logic [63:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = '0;
    logic        M_AXI_RLAST = 1'b0;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    int n_cmp = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];

    ptw_axi_read_master dut (
        .CLK                 (CLK),
        .RSTN                (RSTN),
        .ADDR_FROM_TLB_VALID (ADDR_FROM_TLB_VALID),
        .ADDR_FROM_TLB       (ADDR_FROM_TLB),
        .DATA_TO_TLB_VALID   (DATA_TO_TLB_VALID),
        .DATA_TO_TLB         (DATA_TO_TLB),
        .ACCESS_FAULT        (ACCESS_FAULT),
        .BUSY                (BUSY),
        .REQ_DROPPED         (REQ_DROPPED),
        .M_AXI_ARADDR        (M_AXI_ARADDR),
        .M_AXI_ARVALID       (M_AXI_ARVALID),
        .M_AXI_ARREADY       (M_AXI_ARREADY),
        .M_AXI_ARID          (M_AXI_ARID),
        .M_AXI_ARLEN         (M_AXI_ARLEN),
        .M_AXI_ARSIZE        (M_AXI_ARSIZE),
        .M_AXI_ARBURST       (M_AXI_ARBURST),
        .M_AXI_ARPROT        (M_AXI_ARPROT),
        .M_AXI_RDATA         (M_AXI_RDATA),
        .M_AXI_RRESP         (M_AXI_RRESP),
        .M_AXI_RLAST         (M_AXI_RLAST),
        .M_AXI_RVALID        (M_AXI_RVALID),
        .M_AXI_RREADY        (M_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected response.
    always @(negedge CLK) begin
        if (RSTN && DATA_TO_TLB_VALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("resp_data", DATA_TO_TLB, e[63:0]);
                chk("resp_fault", {63'd0, ACCESS_FAULT}, {63'd0, e[64]});
                chk("resp_rready_low", {63'd0, M_AXI_RREADY}, 64'd0);
            end
        end
    end

    // Full read: called in an IDLE cycle (#1 after an edge), returns in the next IDLE cycle.
    task automatic do_read(input logic [63:0] addr, input int ar_dly, input int r_dly,
                           input logic [63:0] rdata, input logic [1:0] rresp,
                           input logic rlast, input logic exp_fault, input bit inject);
        logic [63:0] exp_ar;
        exp_ar = {8'd0, addr[55:0]};
        ADDR_FROM_TLB       = addr;
        ADDR_FROM_TLB_VALID = 1'b1;
        exp_q.push_back({exp_fault, rdata});
        @(posedge CLK); #1;
        ADDR_FROM_TLB_VALID = 1'b0;
        ADDR_FROM_TLB       = ~addr;
        chk("busy_set", {63'd0, BUSY}, 64'd1);
        for (int i = 0; i <= ar_dly; i++) begin
            chk("arvalid_hold", {63'd0, M_AXI_ARVALID}, 64'd1);
            chk("araddr", {8'd0, M_AXI_ARADDR}, exp_ar);
            chk("rready_in_ar", {63'd0, M_AXI_RREADY}, 64'd0);
            if (i == ar_dly) M_AXI_ARREADY = 1'b1;
            @(posedge CLK); #1;
            M_AXI_ARREADY = 1'b0;
        end
        chk("arvalid_dropped", {63'd0, M_AXI_ARVALID}, 64'd0);
        for (int i = 0; i <= r_dly; i++) begin
            chk("rready_in_r", {63'd0, M_AXI_RREADY}, 64'd1);
            chk("no_second_ar", {63'd0, M_AXI_ARVALID}, 64'd0);
            if (inject && i == 0) ADDR_FROM_TLB_VALID = 1'b1;
            if (i == r_dly) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = rdata;
                M_AXI_RRESP  = rresp;
                M_AXI_RLAST  = rlast;
            end
            @(posedge CLK); #1;
            ADDR_FROM_TLB_VALID = 1'b0;
            M_AXI_RVALID = 1'b0;
            M_AXI_RDATA  = 64'hBAD0_BAD0_BAD0_BAD0;
            M_AXI_RLAST  = 1'b0;
        end
        // RESP cycle: the monitor checks the pulse at the next negedge.
        chk("rready_in_resp", {63'd0, M_AXI_RREADY}, 64'd0);
        chk("arvalid_in_resp", {63'd0, M_AXI_ARVALID}, 64'd0);
        @(posedge CLK); #1;
        chk("pulse_one_cycle", {63'd0, DATA_TO_TLB_VALID}, 64'd0);
        chk("busy_clear", {63'd0, BUSY}, 64'd0);
        chk("fault_clear", {63'd0, ACCESS_FAULT}, 64'd0);
        chk("data_hold", DATA_TO_TLB, rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_arvalid", {63'd0, M_AXI_ARVALID}, 64'd0);
        chk("rst_rready", {63'd0, M_AXI_RREADY}, 64'd0);
        chk("rst_dvalid", {63'd0, DATA_TO_TLB_VALID}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_dropped", {63'd0, REQ_DROPPED}, 64'd0);
        chk("rst_araddr", {8'd0, M_AXI_ARADDR}, 64'd0);
        chk("rst_data", DATA_TO_TLB, 64'd0);
        chk("const_arlen", {56'd0, M_AXI_ARLEN}, 64'd0);
        chk("const_arsize", {61'd0, M_AXI_ARSIZE}, 64'd3);
        chk("const_arburst", {62'd0, M_AXI_ARBURST}, 64'd1);
        chk("const_arprot", {61'd0, M_AXI_ARPROT}, 64'd1);
        chk("const_arid", {60'd0, M_AXI_ARID}, 64'd0);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(posedge CLK); #1;

        // Best-case read
        do_read(64'h0000_8000_0010, 0, 0, 64'h0000_0000_2000_00CF, 2'b00, 1'b1, 1'b0, 1'b0);
        // Delayed ARREADY / RVALID
        do_read(64'h0000_8000_1238, 3, 4, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 1'b0, 1'b0);
        // SLVERR, then a clean read
        do_read(64'h0000_0000_0040, 0, 0, 64'h0000_0000_0000_DEAD, 2'b10, 1'b1, 1'b1, 1'b0);
        do_read(64'h0000_0000_0048, 1, 0, 64'h1111_2222_3333_4444, 2'b00, 1'b1, 1'b0, 1'b0);
        // DECERR, EXOKAY (no fault), missing RLAST (fault)
        do_read(64'h0000_0000_0050, 0, 1, 64'h5555_6666_7777_8888, 2'b11, 1'b1, 1'b1, 1'b0);
        do_read(64'h0000_0000_0058, 0, 0, 64'h9999_AAAA_BBBB_CCCC, 2'b01, 1'b1, 1'b0, 1'b0);
        do_read(64'h0000_0000_0060, 0, 0, 64'hDDDD_EEEE_FFFF_0000, 2'b00, 1'b0, 1'b1, 1'b0);
        // High address bits above the AXI width are discarded
        do_read(64'hFF00_0000_0000_0068, 0, 0, 64'h0000_0000_0000_0ABC, 2'b00, 1'b1, 1'b0, 1'b0);

        chk("dropped_before", {63'd0, REQ_DROPPED}, 64'd0);
        // Pulse during R is dropped; back-to-back request in the IDLE cycle is accepted
        do_read(64'h0000_0000_0070, 0, 2, 64'h0000_0000_0000_7070, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("dropped_set", {63'd0, REQ_DROPPED}, 64'd1);
        do_read(64'h0000_0000_0078, 0, 0, 64'h0000_0000_0000_7878, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("dropped_sticky", {63'd0, REQ_DROPPED}, 64'd1);

        // Reset while ARVALID is high
        ADDR_FROM_TLB       = 64'h0000_0000_0080;
        ADDR_FROM_TLB_VALID = 1'b1;
        @(posedge CLK); #1;
        ADDR_FROM_TLB_VALID = 1'b0;
        chk("pre_rst_arvalid", {63'd0, M_AXI_ARVALID}, 64'd1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_arvalid", {63'd0, M_AXI_ARVALID}, 64'd0);
        chk("arst_rready", {63'd0, M_AXI_RREADY}, 64'd0);
        chk("arst_busy", {63'd0, BUSY}, 64'd0);
        chk("arst_dropped", {63'd0, REQ_DROPPED}, 64'd0);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(posedge CLK); #1;
        do_read(64'h0000_0000_0088, 0, 0, 64'h0000_0000_0000_8888, 2'b00, 1'b1, 1'b0, 1'b0);

        // Misaligned request
`ifdef PTW_ALIGN_CHECK_EN
        ADDR_FROM_TLB       = 64'h0000_0000_0000_1004;
        ADDR_FROM_TLB_VALID = 1'b1;
        exp_q.push_back({1'b1, 64'd0});
        @(posedge CLK); #1;
        ADDR_FROM_TLB_VALID = 1'b0;
        chk("align_no_ar", {63'd0, M_AXI_ARVALID}, 64'd0);
        chk("align_busy", {63'd0, BUSY}, 64'd1);
        @(posedge CLK); #1;
        chk("align_busy_clear", {63'd0, BUSY}, 64'd0);
        chk("align_no_ar_after", {63'd0, M_AXI_ARVALID}, 64'd0);
`else
        do_read(64'h0000_0000_0000_1004, 0, 0, 64'h0000_0000_0000_1004, 2'b00, 1'b1, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
